// File: rtl/tiled_operand_address_generator.sv
// Tiled operand address generator.
// Walks a col_size x row_size tile stored in BRAM, issuing one read per cycle
// (unless stalled), and replays each read READ_LATENCY cycles later as a write
// into a local operand RAM. The dataflow mode selects which tile dimension is
// the fast-moving (inner) loop: rows for weight-stationary, columns for
// output-stationary.
module tiled_operand_address_generator #(
  parameter int INTEGER_BIT     = 7,
  parameter int RAM_ADDR_WIDTH  = 7,
  parameter int BRAM_ADDR_WIDTH = 32,
  parameter int READ_LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stall,
  input  logic                       ws_os,
  input  logic [INTEGER_BIT-1:0]     col_size,
  input  logic [INTEGER_BIT-1:0]     row_size,
  input  logic [INTEGER_BIT-1:0]     bram_row_size,
  input  logic [INTEGER_BIT-1:0]     bram_col_start_index,
  input  logic [INTEGER_BIT-1:0]     bram_row_start_index,
  input  logic [RAM_ADDR_WIDTH-1:0]  ram_start_addr,
  output logic                       busy,
  output logic                       done,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic                       bram_en,
  output logic                       ram_write_req,
  output logic [RAM_ADDR_WIDTH-1:0]  ram_write_addr,
  output logic [INTEGER_BIT-1:0]     ram_index_addr
);

  // Element count is a full product so a maximal tile never wraps the count.
  localparam int CNT_W  = 2 * INTEGER_BIT;
  // A BRAM index is start + offset, so it needs one bit more than either term.
  localparam int IDX_W  = INTEGER_BIT + 1;
  // Width holding col_idx * bram_row_size + row_idx without overflow.
  localparam int CALC_W = 2 * INTEGER_BIT + 2;
  localparam int LAST   = READ_LATENCY - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Configuration captured when a transfer is accepted.
  typedef struct packed {
    logic                      ws_os;
    logic [INTEGER_BIT-1:0]    col_size;
    logic [INTEGER_BIT-1:0]    row_size;
    logic [INTEGER_BIT-1:0]    bram_row_size;
    logic [INTEGER_BIT-1:0]    col_start;
    logic [INTEGER_BIT-1:0]    row_start;
    logic [RAM_ADDR_WIDTH-1:0] ram_start;
  } cfg_t;

  state_t                 state;
  cfg_t                   cfg;
  logic [INTEGER_BIT-1:0] inner;
  logic [INTEGER_BIT-1:0] outer;
  logic [CNT_W-1:0]       issue_cnt;
  logic [CNT_W-1:0]       elem_total;

  logic [INTEGER_BIT-1:0] inner_ext;
  logic [INTEGER_BIT-1:0] row_off;
  logic [INTEGER_BIT-1:0] col_off;
  logic [IDX_W-1:0]       row_idx;
  logic [IDX_W-1:0]       col_idx;
  logic [CALC_W-1:0]      addr_calc;
  logic                   issue;
  logic                   inner_wrap;
  logic                   last_issue;
  logic                   pipe_upstream;

  // Read-return pipeline: one entry per cycle of BRAM latency.
  logic                   pipe_valid [READ_LATENCY];
  logic [INTEGER_BIT-1:0] pipe_outer [READ_LATENCY];
  logic [INTEGER_BIT-1:0] pipe_inner [READ_LATENCY];

  // Issue decision and BRAM address, derived directly from the live counters.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    inner_ext  = cfg.ws_os ? cfg.col_size : cfg.row_size;
    row_off    = cfg.ws_os ? outer : inner;
    col_off    = cfg.ws_os ? inner : outer;
    issue      = (state == ISSUE) && !stall;
    inner_wrap = (inner == inner_ext - INTEGER_BIT'(1));
    last_issue = (issue_cnt == elem_total - CNT_W'(1));
    row_idx    = {1'b0, cfg.row_start} + {1'b0, row_off};
    col_idx    = {1'b0, cfg.col_start} + {1'b0, col_off};
    addr_calc  = CALC_W'(col_idx) * CALC_W'(cfg.bram_row_size) + CALC_W'(row_idx);
    bram_en    = issue;
    bram_addr  = '0;
    if (issue) begin
      bram_addr = BRAM_ADDR_WIDTH'(addr_calc);
    end
  end

  // Any read still in flight ahead of the final stage keeps DRAIN waiting.
  always_comb begin
    pipe_upstream = 1'b0;
    for (int i = 0; i < LAST; i++) begin
      pipe_upstream = pipe_upstream | pipe_valid[i];
    end
  end

  // Control FSM: accept, walk the tile, wait for returns, pulse done.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples the pre-edge values regardless of block ordering.
    if (rst) begin
      state      <= IDLE;
      cfg        <= '0;
      inner      <= '0;
      outer      <= '0;
      issue_cnt  <= '0;
      elem_total <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cfg        <= '{ws_os:         ws_os,
                            col_size:      col_size,
                            row_size:      row_size,
                            bram_row_size: bram_row_size,
                            col_start:     bram_col_start_index,
                            row_start:     bram_row_start_index,
                            ram_start:     ram_start_addr};
            elem_total <= CNT_W'(col_size) * CNT_W'(row_size);
            inner      <= '0;
            outer      <= '0;
            issue_cnt  <= '0;
            busy       <= 1'b1;
            if ((col_size == '0) || (row_size == '0)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
            if (last_issue) begin
              state <= DRAIN;
              inner <= '0;
              outer <= '0;
            end else if (inner_wrap) begin
              inner <= '0;
              outer <= outer + INTEGER_BIT'(1);
            end else begin
              inner <= inner + INTEGER_BIT'(1);
            end
          end
        end
        DRAIN: begin
          if (!pipe_upstream) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid bits of the read-return pipeline; advance every cycle, stall or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  // Payload of the read-return pipeline, qualified by the valid bits.
  always_ff @(posedge clk) begin
    // NOTE: payload storage is deliberately left without reset; clearing the
    // valid bits is enough because every consumer is gated by them.
    pipe_outer[0] <= outer;
    pipe_inner[0] <= inner;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_outer[i] <= pipe_outer[i-1];
      pipe_inner[i] <= pipe_inner[i-1];
    end
  end

  // Local RAM write port, zero whenever no write is being requested.
  always_comb begin
    ram_write_req  = pipe_valid[LAST];
    ram_write_addr = '0;
    ram_index_addr = '0;
    if (pipe_valid[LAST]) begin
      ram_write_addr = cfg.ram_start + RAM_ADDR_WIDTH'(pipe_outer[LAST]);
      ram_index_addr = pipe_inner[LAST];
    end
  end

endmodule

// File: tb/tb_tiled_operand_address_generator.sv
// Scoreboard bench for tiled_operand_address_generator.
// Stimulus pushes hand-computed reads/writes/done timing into queues; a
// negedge monitor pops and compares whenever the DUT presents an event.
module tb_tiled_operand_address_generator;

  localparam int IB  = 7;
  localparam int RAW = 7;
  localparam int BAW = 32;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           stall;
  logic           ws_os;
  logic [IB-1:0]  col_size;
  logic [IB-1:0]  row_size;
  logic [IB-1:0]  bram_row_size;
  logic [IB-1:0]  bram_col_start_index;
  logic [IB-1:0]  bram_row_start_index;
  logic [RAW-1:0] ram_start_addr;
  logic           busy;
  logic           done;
  logic [BAW-1:0] bram_addr;
  logic           bram_en;
  logic           ram_write_req;
  logic [RAW-1:0] ram_write_addr;
  logic [IB-1:0]  ram_index_addr;

  tiled_operand_address_generator #(
    .INTEGER_BIT    (IB),
    .RAM_ADDR_WIDTH (RAW),
    .BRAM_ADDR_WIDTH(BAW),
    .READ_LATENCY   (LAT)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .stall               (stall),
    .ws_os               (ws_os),
    .col_size            (col_size),
    .row_size            (row_size),
    .bram_row_size       (bram_row_size),
    .bram_col_start_index(bram_col_start_index),
    .bram_row_start_index(bram_row_start_index),
    .ram_start_addr      (ram_start_addr),
    .busy                (busy),
    .done                (done),
    .bram_addr           (bram_addr),
    .bram_en             (bram_en),
    .ram_write_req       (ram_write_req),
    .ram_write_addr      (ram_write_addr),
    .ram_index_addr      (ram_index_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // Scoreboard queues. exp_done holds the cycle done must appear in, or -1
  // meaning "the cycle after the last write".
  int exp_addr[$];
  int exp_wa[$];
  int exp_wi[$];
  int exp_done[$];
  int wr_due[$];
  int last_wr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every DUT event against the scoreboard.
  always @(negedge clk) begin
    int e;
    if (stall) check("bram_en_during_stall", bram_en, 0);
    if (bram_en) begin
      if (exp_addr.size() == 0) check("bram_en_unexpected", bram_en, 0);
      else begin
        check("bram_addr", bram_addr, exp_addr.pop_front());
        wr_due.push_back(cyc + LAT);
      end
    end else begin
      check("bram_addr_gated", bram_addr, 0);
    end
    if (ram_write_req) begin
      if (exp_wa.size() == 0) check("ram_write_unexpected", ram_write_req, 0);
      else begin
        check("ram_write_addr", ram_write_addr, exp_wa.pop_front());
        check("ram_index_addr", ram_index_addr, exp_wi.pop_front());
        if (wr_due.size() != 0) check("ram_write_latency", cyc, wr_due.pop_front());
        last_wr = cyc;
      end
    end else begin
      check("ram_write_addr_gated", ram_write_addr, 0);
      check("ram_index_addr_gated", ram_index_addr, 0);
    end
    if (done) begin
      if (exp_done.size() == 0) check("done_unexpected", done, 0);
      else begin
        e = exp_done.pop_front();
        check("done_cycle", cyc, (e < 0) ? last_wr + 1 : e);
        check("busy_at_done", busy, 1);
      end
    end
  end

  task automatic push_rd(input int a);
    exp_addr.push_back(a);
  endtask

  task automatic push_wr(input int wa, input int wi);
    exp_wa.push_back(wa);
    exp_wi.push_back(wi);
  endtask

  task automatic drive_cfg(input logic ws, input int col, input int row, input int brs,
                           input int cs, input int rs, input int ram);
    ws_os                = ws;
    col_size             = IB'(col);
    row_size             = IB'(row);
    bram_row_size        = IB'(brs);
    bram_col_start_index = IB'(cs);
    bram_row_start_index = IB'(rs);
    ram_start_addr       = RAW'(ram);
  endtask

  // One-cycle start pulse; config is scrambled afterwards to prove it was latched.
  task automatic launch(input logic ws, input int col, input int row, input int brs,
                        input int cs, input int rs, input int ram, input bit zero);
    @(posedge clk); #1;
    // A zero-sized tile goes straight to DONE on the accepting edge, so done
    // is high in the very next cycle (captured by the second edge after drive).
    if (zero) exp_done.push_back(cyc + 1);
    else      exp_done.push_back(-1);
    drive_cfg(ws, col, row, brs, cs, rs, ram);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drive_cfg(~ws, 5, 5, 3, 7, 9, 99);
  endtask

  task automatic wait_drained(input string tag);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((exp_addr.size() != 0 || exp_wa.size() != 0 || exp_done.size() != 0 || busy)
               && n < 3000);
    check({tag, "_completed"}, n < 3000, 1);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic wait_reads_left(input int left, input string tag);
    int n = 0;
    while (exp_addr.size() > left && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_reads_seen"}, n < 200, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_bram_en"}, bram_en, 0);
    check({tag, "_bram_addr"}, bram_addr, 0);
    check({tag, "_wr_req"}, ram_write_req, 0);
    check({tag, "_wr_addr"}, ram_write_addr, 0);
    check({tag, "_wr_idx"}, ram_index_addr, 0);
  endtask

  // Hand-computed vectors: WS 2x3 and OS 2x3 (origin 0, stride 8, ram 4),
  // and OS 3x2 with origin (col 1,row 2), stride 5, ram 10.
  int ws_a[6]  = '{0, 1, 2, 8, 9, 10};
  int ws_wa[6] = '{4, 4, 4, 5, 5, 5};
  int ws_wi[6] = '{0, 1, 2, 0, 1, 2};
  int os_a[6]  = '{0, 8, 1, 9, 2, 10};
  int os_wa[6] = '{4, 4, 5, 5, 6, 6};
  int os_wi[6] = '{0, 1, 0, 1, 0, 1};
  int og_a[6]  = '{7, 12, 17, 8, 13, 18};
  int og_wa[6] = '{10, 10, 10, 11, 11, 11};
  int og_wi[6] = '{0, 1, 2, 0, 1, 2};

  task automatic push_ws;
    for (int i = 0; i < 6; i++) begin
      push_rd(ws_a[i]);
      push_wr(ws_wa[i], ws_wi[i]);
    end
  endtask

  task automatic push_origin;
    for (int i = 0; i < 6; i++) begin
      push_rd(og_a[i]);
      push_wr(og_wa[i], og_wi[i]);
    end
  endtask

  initial begin
    // Reset held with start asserted: reset must win.
    rst   = 1'b1;
    start = 1'b1;
    stall = 1'b0;
    drive_cfg(0, 2, 3, 8, 0, 0, 4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_priority_busy", busy, 0);

    // WS 2x3, with an ignored start pulse (different config) while busy.
    push_ws();
    launch(0, 2, 3, 8, 0, 0, 4, 0);
    check("busy_after_accept", busy, 1);
    @(posedge clk); #1;
    drive_cfg(1, 1, 1, 1, 1, 1, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drained("ws_2x3");

    // OS 2x3.
    for (int i = 0; i < 6; i++) begin
      push_rd(os_a[i]);
      push_wr(os_wa[i], os_wi[i]);
    end
    launch(1, 2, 3, 8, 0, 0, 4, 0);
    wait_drained("os_2x3");

    // WS 2x3 with a three-cycle stall after the second read.
    push_ws();
    launch(0, 2, 3, 8, 0, 0, 4, 0);
    wait_reads_left(4, "stall");
    @(posedge clk); #1;
    stall = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    stall = 1'b0;
    wait_drained("stall_2x3");

    // OS 3x2 from a non-zero origin.
    push_origin();
    launch(1, 3, 2, 5, 1, 2, 10, 0);
    wait_drained("origin_os_3x2");

    // Zero-sized tiles: col=0, then row=0.
    launch(0, 0, 3, 8, 0, 0, 4, 1);
    wait_drained("zero_col");
    launch(1, 4, 0, 8, 0, 0, 4, 1);
    wait_drained("zero_row");

    // Reset during DRAIN: the write of the last element must never appear.
    push_ws();
    launch(0, 2, 3, 8, 0, 0, 4, 0);
    wait_reads_left(0, "abort");
    @(posedge clk); #1;
    rst = 1'b1;
    void'(exp_wa.pop_back());
    void'(exp_wi.pop_back());
    if (wr_due.size() != 0) void'(wr_due.pop_back());
    void'(exp_done.pop_back());
    @(posedge clk);
    @(negedge clk);
    check_all_zero("abort");
    check("abort_writes_before_reset", exp_wa.size(), 0);
    #1;
    rst = 1'b0;
    wr_due.delete();
    repeat (4) @(negedge clk);
    check("abort_no_restart", busy, 0);

    // A fresh transfer after the abort runs normally.
    push_origin();
    launch(1, 3, 2, 5, 1, 2, 10, 0);
    wait_drained("after_abort");

    // 16x16 WS tile from ram row 127: write rows wrap 127,0,...,14.
    for (int o = 0; o < 16; o++) begin
      for (int i = 0; i < 16; i++) begin
        push_rd(o * 16 + i);
        push_wr((127 + o) % 128, i);
      end
    end
    launch(0, 16, 16, 16, 0, 0, 127, 0);
    wait_drained("big_16x16");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
